// File: rtl/pcie_rx_merge.sv
// Two-lane receive merge: a small FIFO per lane feeds a round-robin arbiter
// that drives one registered, stallable output stream, under an INIT/IDLE/ACTIVE/ERROR FSM.

module pcie_rx_lane #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              en,
  input  logic              load_thr,
  input  logic [AW-1:0]     umbral,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] head,
  output logic [AW:0]       count,
  output logic              nempty,
  output logic              pause,
  output logic              ovf
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, thr_reg;
  logic [AW:0]       thr;
  logic              full, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign nempty  = (count != '0);
  assign do_pop  = en & pop;
  // A push into a full lane still lands when the same lane pops this cycle.
  assign do_push = en & push & (~full | do_pop);
  assign ovf     = en & push & full & ~do_pop;
  assign head    = mem[rd_ptr];
  // Threshold 0 stands for DEPTH: pause only when completely full.
  assign thr     = (thr_reg == '0) ? (AW+1)'(DEPTH) : {1'b0, thr_reg};
  assign pause   = (count >= thr);

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data_in;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      thr_reg <= '0;
    end else begin
      if (load_thr) thr_reg <= umbral;
      if (do_push)  wr_ptr  <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr  <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module pcie_rx_merge #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [AW-1:0]     umbral_D0,
  input  logic [AW-1:0]     umbral_D1,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              push0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              push1,
  input  logic              pause_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              pause_in0,
  output logic              pause_in1,
  output logic              idle_out,
  output logic              active_out,
  output logic              error_out
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
  state_t state;

  logic [NUM_LANES-1:0]             push, pop, nempty, pause, ovf;
  logic [NUM_LANES-1:0][DATA_W-1:0] din, head;
  logic [NUM_LANES-1:0][AW:0]       count;
  logic [NUM_LANES-1:0][AW-1:0]     umbral;
  logic                             en, can_arb, last_grant;

  assign push    = {push1, push0};
  assign din     = {data_in1, data_in0};
  assign umbral  = {umbral_D1, umbral_D0};
  assign en      = (state != S_ERROR);
  assign can_arb = en & ~pause_out;

  // Round-robin: on a tie the lane that did not win last time goes.
  assign pop[0] = can_arb & nempty[0] & (~nempty[1] | last_grant);
  assign pop[1] = can_arb & nempty[1] & (~nempty[0] | ~last_grant);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pcie_rx_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk      (clk),
      .reset_L  (reset_L),
      .en       (en),
      .load_thr (state == S_INIT),
      .umbral   (umbral[l]),
      .push     (push[l]),
      .pop      (pop[l]),
      .data_in  (din[l]),
      .head     (head[l]),
      .count    (count[l]),
      .nempty   (nempty[l]),
      .pause    (pause[l]),
      .ovf      (ovf[l])
    );
  end

  assign pause_in0  = pause[0];
  assign pause_in1  = pause[1];
  assign idle_out   = (state == S_IDLE);
  assign active_out = (state == S_ACTIVE);
  assign error_out  = (state == S_ERROR);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      valid_out <= |pop;
      if (pop[0]) begin
        data_out   <= head[0];
        last_grant <= 1'b0;
      end else if (pop[1]) begin
        data_out   <= head[1];
        last_grant <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= S_INIT;
    else if (state == S_ERROR || (|ovf)) state <= S_ERROR;
    else if (init) state <= S_INIT;
    else begin
      case (state)
        S_INIT:   state <= S_IDLE;
        S_IDLE:   if (|nempty) state <= S_ACTIVE;
        S_ACTIVE: if (~(|nempty) && !valid_out) state <= S_IDLE;
        default:  state <= state;
      endcase
    end
  end
endmodule
